hero_palette_arbiter: RTL and testbench
=======================================

Name: hero_palette_arbiter

Overview:
Shares the single 8-entry hero palette lookup (3-bit index -> 12-bit RGB, 4/4/4) among NREQ sprite-pixel requesters, e.g. hero body, hero weapon flash and two bullet renderers.
Grants one request per cycle using round-robin priority. Returns the registered RGB with the requester ID and a transparency flag to the frame-buffer writer.
The output stage is single-entry and honours backpressure from the writer.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, $clog2(NREQ), width of requester ID (derived, do not override)
TRANSPARENT_IDX, 3'd0, palette index reported as transparent

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_index  in  3*NREQ  palette index; requester i uses bits [3i+2:3i]
req_ready  out  NREQ  per-requester accept (one-hot or zero)
rsp_valid  out  1  response valid
rsp_ready  in  1  writer accepts response
rsp_id  out  ID_W  requester that owns the response
rsp_rgb  out  12  {red,green,blue} from palette
rsp_transparent  out  1  1 when looked-up index == TRANSPARENT_IDX

Behaviour:
- Interface: one clock Clk; reset Reset_n asynchronous, active-low. Assertion clears all state immediately. Release is synchronous to Clk, from an external synchroniser.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_rgb=12'h000, rsp_transparent=0.
  - Round-robin pointer rr_ptr=0, so requester 0 has top priority first.
- Stage free condition: stage_free = !rsp_valid || rsp_ready.
- Grant:
  - When stage_free, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = one-hot grant when stage_free, else all zero. It is combinational from req_valid, rr_ptr, rsp_valid and rsp_ready.
  - req_ready must never depend on req_index.
- Transfer: a request is taken when req_valid[i] && req_ready[i].
- Latency: the response is registered 1 cycle after acceptance.
  - On the accepting edge, load rsp_valid=1, rsp_id=i, rsp_rgb=palette[index], rsp_transparent=(index==TRANSPARENT_IDX).
- Pointer update: after a grant to i, rr_ptr <= (i+1) mod NREQ, wrapping NREQ-1 -> 0. With no grant, rr_ptr holds.
- Hold: if rsp_valid && !rsp_ready, all rsp_* outputs hold stable and there are no grants.
- Simultaneous consume and new accept (rsp_ready=1 and a grant in the same cycle):
  - The new response replaces the old one. rsp_valid stays 1, giving back-to-back throughput of 1 per cycle.
- Drain: rsp_ready=1 with no grant -> rsp_valid <= 0. The data registers may hold their stale values.
- Requesters: a requester must hold req_valid and req_index stable until accepted. The arbiter does not latch unaccepted requests.
- Reset mid-operation: a pending response is discarded and rr_ptr returns to 0. No req_ready is asserted while Reset_n=0.
- Palette contents (index: RGB): 0:631, 1:0E0, 2:05E, 3:DBA, 4:000, 5:E30, 6:028, 7:070.

Decomposition:
- Package hero_gfx_pkg holds:
  - typedef pal_idx_t (logic [2:0]);
  - typedef rgb12_t (struct of red, green and blue, 4 bits each);
  - constant PAL_TRANSPARENT = 3'd0;
  - function rr_next(ptr, grant_idx, n).
- One natural sub-module, rr_arbiter_core. Parameter NREQ; inputs req, enable, rr_ptr; outputs grant one-hot and grant_idx. It is purely combinational; rr_ptr is the arbiter's state.
- The palette ROM is instantiated as-is, with index from the granted request mux.

Test Plan:
1. Reset, then drive req_valid=4'b0010 with req1 index=5 and rsp_ready=1.
   -> req_ready=4'b0010 that cycle; next cycle rsp_valid=1, rsp_id=1, rsp_rgb=12'hE30, rsp_transparent=0; rr_ptr=2.
2. All four requesters valid and held for 8 cycles, indices 1,2,3,4, rsp_ready=1.
   -> grant order 0,1,2,3,0,1,2,3; rsp_rgb sequence 0E0,05E,DBA,000 repeating; rsp_valid continuously 1.
3. Backpressure: response pending (id 2, 12'hDBA), rsp_ready=0 for 3 cycles, other requests valid.
   -> req_ready=0 and rsp_* stable for 3 cycles. On the cycle rsp_ready=1, grant goes to requester 3 and the response updates the next cycle.
4. Transparency: requester 0 index=0.
   -> rsp_rgb=12'h631, rsp_transparent=1. Requester 0 index=7 -> rsp_rgb=12'h070, rsp_transparent=0.
5. Wrap-around: rr_ptr=3, requests from 0 and 3.
   -> 3 granted first, then 0; rr_ptr goes 3 -> 0 -> 1.
6. Assert Reset_n low mid-burst with a response pending.
   -> rsp_valid=0 immediately (asynchronous). After release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/hero_gfx_pkg.sv
// Shared types and helpers for the hero sprite palette path: the palette index
// and RGB types, the transparent index, the round-robin pointer step and the
// 8-entry hero palette ROM.
package hero_gfx_pkg;

    typedef logic [2:0] pal_idx_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb12_t;

    localparam pal_idx_t PAL_TRANSPARENT = 3'd0;

    // Next round-robin pointer after a grant to grant_idx among n requesters.
    // The pointer lands just past the winner and wraps n-1 -> 0. An
    // out-of-range index leaves the pointer where it was.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned grant_idx,
                                            input int unsigned n);
        int unsigned nxt;
        if (grant_idx >= n) begin
            nxt = ptr;
        end else if (grant_idx == n - 1) begin
            nxt = 0;
        end else begin
            nxt = grant_idx + 1;
        end
        return nxt;
    endfunction

    // Hero palette ROM, 4/4/4 RGB.
    function automatic rgb12_t palette_lookup(input pal_idx_t idx);
        rgb12_t rgb;
        case (idx)
            3'd0:    rgb = rgb12_t'(12'h631);
            3'd1:    rgb = rgb12_t'(12'h0E0);
            3'd2:    rgb = rgb12_t'(12'h05E);
            3'd3:    rgb = rgb12_t'(12'hDBA);
            3'd4:    rgb = rgb12_t'(12'h000);
            3'd5:    rgb = rgb12_t'(12'hE30);
            3'd6:    rgb = rgb12_t'(12'h028);
            default: rgb = rgb12_t'(12'h070);
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker. Searches rr_ptr, rr_ptr+1, ... mod NREQ
// and grants the first valid requester. The pointer lives in the caller.
module rr_arbiter_core #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic found;

    // Priority search that starts at the pointer. The outer loop is the
    // distance from the pointer; the inner loop finds the requester at that
    // distance.
    always_comb begin
        // NOTE: every output of this block gets a default first, so the
        // no-grant path never holds an old value and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (enable && !found && req[i] &&
                    (((int'(rr_ptr) + k) % NREQ) == i)) begin
                    grant[i]  = 1'b1;
                    grant_idx = ID_W'(i);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hero_palette_arbiter.sv
// Shares the hero palette lookup among NREQ sprite-pixel requesters. One
// round-robin grant per cycle feeds a single-entry registered response stage
// that honours backpressure from the frame-buffer writer.
module hero_palette_arbiter
    import hero_gfx_pkg::*;
#(
    parameter  int       NREQ            = 4,   // 2..8
    parameter  pal_idx_t TRANSPARENT_IDX = PAL_TRANSPARENT,
    localparam int       ID_W            = $clog2(NREQ)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_index,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [11:0]       rsp_rgb,
    output logic              rsp_transparent
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    rgb12_t          rsp_rgb_q, rsp_rgb_d;
    logic            rsp_transparent_q, rsp_transparent_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            stage_free;
    logic            grant_en;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            any_grant;
    pal_idx_t        sel_index;

    // The stage can take a new pixel when empty or when its current pixel
    // leaves this cycle. Grants are also blocked while reset is held, since
    // the emptied stage would otherwise look free.
    assign stage_free = !rsp_valid_q || rsp_ready;
    assign grant_en   = stage_free && Reset_n;

    rr_arbiter_core #(.NREQ(NREQ)) u_rr_core (
        .req       (req_valid),
        .enable    (grant_en),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    // Index mux for the granted requester; only the data path sees
    // req_index, so req_ready never depends on it.
    always_comb begin
        sel_index = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_index = req_index[3*i +: 3];
            end
        end
    end

    // Next state: load on grant (replacing any pixel leaving this cycle),
    // drain when consumed with nothing new, otherwise hold.
    always_comb begin
        rsp_valid_d       = rsp_valid_q;
        rsp_id_d          = rsp_id_q;
        rsp_rgb_d         = rsp_rgb_q;
        rsp_transparent_d = rsp_transparent_q;
        rr_ptr_d          = rr_ptr_q;
        if (any_grant) begin
            rsp_valid_d       = 1'b1;
            rsp_id_d          = grant_idx;
            rsp_rgb_d         = palette_lookup(sel_index);
            rsp_transparent_d = (sel_index == TRANSPARENT_IDX);
            rr_ptr_d          = ID_W'(rr_next(32'(rr_ptr_q), 32'(grant_idx), 32'(NREQ)));
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset clears the response stage and the pointer.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid_q       <= 1'b0;
            rsp_id_q          <= '0;
            rsp_rgb_q         <= '0;
            rsp_transparent_q <= 1'b0;
            rr_ptr_q          <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of order.
            rsp_valid_q       <= rsp_valid_d;
            rsp_id_q          <= rsp_id_d;
            rsp_rgb_q         <= rsp_rgb_d;
            rsp_transparent_q <= rsp_transparent_d;
            rr_ptr_q          <= rr_ptr_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = rsp_id_q;
    assign rsp_rgb         = rsp_rgb_q;
    assign rsp_transparent = rsp_transparent_q;

endmodule

// File: tb/tb_hero_palette_arbiter.sv
// Bench for hero_palette_arbiter (NREQ=4). Directed vectors carry the
// expected grant and palette colour; each expected grant pushes a response
// into a scoreboard queue that a separate monitor pops on every handshake.
module tb_hero_palette_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              Clk;
    logic              Reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_index;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [11:0]       rsp_rgb;
    logic              rsp_transparent;

    hero_palette_arbiter #(.NREQ(NREQ)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .req_valid       (req_valid),
        .req_index       (req_index),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_rgb         (rsp_rgb),
        .rsp_transparent (rsp_transparent)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [11:0]     rgb;
        logic            tr;
    } exp_rsp_t;

    exp_rsp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pk(input logic [2:0] i0, input logic [2:0] i1,
                                       input logic [2:0] i2, input logic [2:0] i3);
        return {i3, i2, i1, i0};
    endfunction

    function automatic logic [ID_W-1:0] oh2id(input logic [NREQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    // One cycle: drive inputs just after a rising edge, check req_ready at the
    // falling edge, queue the expected response, then cross the next edge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [11:0] idx, input logic rdy,
                         input logic [NREQ-1:0] exp_rdy, input logic [11:0] exp_rgb,
                         input logic exp_tr);
        exp_rsp_t e;
        req_valid = v;
        req_index = idx;
        rsp_ready = rdy;
        @(negedge Clk);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            e.id  = oh2id(exp_rdy);
            e.rgb = exp_rgb;
            e.tr  = exp_tr;
            sb_q.push_back(e);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic check_held(input string name);
        check({name, "_valid"}, 32'(rsp_valid), 32'(1'b1));
        check({name, "_id"},    32'(rsp_id),    32'(2'd2));
        check({name, "_rgb"},   32'(rsp_rgb),   32'(12'hDBA));
        check({name, "_tr"},    32'(rsp_transparent), 32'(1'b0));
    endtask

    // Monitor: a response is consumed at the next edge whenever valid and
    // ready are both high at the falling edge.
    initial begin
        exp_rsp_t e;
        forever begin
            @(negedge Clk);
            if (Reset_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got id %0d rgb %0h expected no response", rsp_id, rsp_rgb);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id",  32'(rsp_id),  32'(e.id));
                    check("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
                    check("rsp_tr",  32'(rsp_transparent), 32'(e.tr));
                end
            end
        end
    end

    initial begin
        Reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_index = '0;
        rsp_ready = 1'b0;
        #12;
        check("rst_valid",     32'(rsp_valid), 32'(1'b0));
        check("rst_id",        32'(rsp_id),    32'(2'd0));
        check("rst_rgb",       32'(rsp_rgb),   32'(12'h000));
        check("rst_tr",        32'(rsp_transparent), 32'(1'b0));
        check("rst_req_ready", 32'(req_ready), 32'(4'b0000));
        req_valid = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Single request from 1 (index 5), then 3 alone to bring the pointer to 0.
        cycle(4'b0010, pk(3'd0, 3'd5, 3'd0, 3'd0), 1'b1, 4'b0010, 12'hE30, 1'b0);
        check("t1_valid", 32'(rsp_valid), 32'(1'b1));
        cycle(4'b1000, pk(3'd0, 3'd0, 3'd0, 3'd4), 1'b1, 4'b1000, 12'h000, 1'b0);

        // All four valid for 8 cycles: strict rotation at full throughput.
        for (int r = 0; r < 2; r++) begin
            cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b0001, 12'h0E0, 1'b0);
            cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b0010, 12'h05E, 1'b0);
            cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b0100, 12'hDBA, 1'b0);
            cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b1000, 12'h000, 1'b0);
            check("t2_valid", 32'(rsp_valid), 32'(1'b1));
        end

        // Backpressure with id 2 / DBA pending, then release grants 3.
        cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b0001, 12'h0E0, 1'b0);
        cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b0010, 12'h05E, 1'b0);
        cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b0100, 12'hDBA, 1'b0);
        for (int h = 0; h < 3; h++) begin
            cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b0, 4'b0000, 12'h000, 1'b0);
            check_held("t3_hold");
        end
        cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b1000, 12'h000, 1'b0);

        // Transparency: index 0 is transparent, index 7 is not.
        cycle(4'b0001, pk(3'd0, 3'd0, 3'd0, 3'd0), 1'b1, 4'b0001, 12'h631, 1'b1);
        cycle(4'b0001, pk(3'd7, 3'd0, 3'd0, 3'd0), 1'b1, 4'b0001, 12'h070, 1'b0);

        // Wrap-around: pointer to 3 via a grant to 2, then 3 before 0, then
        // pointer 1 makes 3 win again over 0.
        cycle(4'b0100, pk(3'd0, 3'd0, 3'd6, 3'd0), 1'b1, 4'b0100, 12'h028, 1'b0);
        cycle(4'b1001, pk(3'd2, 3'd0, 3'd0, 3'd3), 1'b1, 4'b1000, 12'hDBA, 1'b0);
        cycle(4'b1001, pk(3'd2, 3'd0, 3'd0, 3'd3), 1'b1, 4'b0001, 12'h05E, 1'b0);
        cycle(4'b1001, pk(3'd2, 3'd0, 3'd0, 3'd3), 1'b1, 4'b1000, 12'hDBA, 1'b0);
        cycle(4'b0000, pk(3'd0, 3'd0, 3'd0, 3'd0), 1'b1, 4'b0000, 12'h000, 1'b0);
        check("drain_valid", 32'(rsp_valid), 32'(1'b0));

        // Reset mid-burst with a response pending (pointer left at 1).
        cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b0, 4'b0001, 12'h0E0, 1'b0);
        cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b0, 4'b0000, 12'h000, 1'b0);
        check("t6_pending", 32'(rsp_valid), 32'(1'b1));
        #1;
        Reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("t6_async_valid", 32'(rsp_valid), 32'(1'b0));
        check("t6_rst_ready",   32'(req_ready), 32'(4'b0000));
        req_valid = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        cycle(4'b1111, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 4'b0001, 12'h0E0, 1'b0);
        cycle(4'b0000, pk(3'd0, 3'd0, 3'd0, 3'd0), 1'b1, 4'b0000, 12'h000, 1'b0);
        cycle(4'b0000, pk(3'd0, 3'd0, 3'd0, 3'd0), 1'b1, 4'b0000, 12'h000, 1'b0);

        check("sb_left", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
